reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port (w_enable/w_addr/w_data) between two writeback sources.
- Source A is the in-order pipeline writeback: fixed priority, never back-pressured, passed through in the same cycle.
- Source B is the long-latency unit (load/mul/div): valid/ready handshake into a small FIFO, drained to the write port when A is idle.
- Also drives per-read-port pending flags for the hazard unit, and a starvation stall request back to the pipeline.

Parameters:
- DEPTH, 2, number of B FIFO entries; legal range 1..8.
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose the port before stall_a asserts; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstd  in  1  reset, asynchronous, active-low.
- a_valid  in  1  pipeline writeback valid.
- a_addr  in  5  pipeline destination register.
- a_data  in  32  pipeline writeback data.
- b_valid  in  1  long-latency unit result valid.
- b_ready  out  1  FIFO can accept; equals !full.
- b_addr  in  5  long-latency destination register.
- b_data  in  32  long-latency result data.
- w_enable  out  1  register file write enable.
- w_addr  out  5  register file write address.
- w_data  out  32  register file write data.
- rs1_addr  in  5  decode read address 1.
- rs2_addr  in  5  decode read address 2.
- rs1_pending  out  1  a queued B entry targets rs1_addr.
- rs2_pending  out  1  a queued B entry targets rs2_addr.
- stall_a  out  1  registered request for the pipeline to hold A idle.
- fifo_count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (rstd=0, async): FIFO emptied (head/tail pointers and count = 0), starve counter = 0, stall_a = 0. Consequently b_ready = 1, rs*_pending = 0, fifo_count = 0. w_enable is forced to 0 while rstd = 0.
- Enqueue: B handshake when b_valid && b_ready, captured at posedge. An entry with b_addr = 0 is accepted but not stored, so count is unchanged.
- b_ready depends only on full, not on a same-cycle dequeue. When full, b_ready = 0 even if the head drains that cycle.
- Write port is combinational with fixed priority:
  - If rstd && a_valid && a_addr != 0: w_enable = 1, w_addr/w_data = a_addr/a_data.
  - Else if the FIFO is non-empty: w_enable = 1, w_addr/w_data = head entry; head pops at that posedge.
  - Else: w_enable = 0, w_addr = 0, w_data = 0.
- a_valid with a_addr = 0 counts as idle, and the FIFO head may use the port.
- Latency: A writes in the same cycle it is valid. An accepted B entry writes no earlier than the cycle after acceptance; there is no empty-FIFO bypass.
- B entries write strictly in acceptance order.
- Simultaneous enqueue and dequeue: count is unchanged and the pointers advance independently, wrapping modulo DEPTH.
- Pending flags: rsN_pending = (rsN_addr != 0) && any occupied entry has addr == rsN_addr.
  - Flags cover stored entries only. The hazard unit ORs in b_valid/b_addr itself.
  - An entry stops being pending the cycle after it is written.
- Starve counter:
  - Increments when the FIFO is non-empty and A holds the port; saturates at STARVE_LIMIT.
  - Clears to 0 on any cycle the head is written, or when the FIFO is empty.
  - stall_a is registered: stall_a <= (next counter value == STARVE_LIMIT).
- While stall_a = 1 the pipeline must hold a_valid = 0. If a_valid is asserted anyway, A still wins the port; the counter stays saturated and stall_a stays 1.
- WAW hazard: A writing to an address that is pending in the FIFO is prevented upstream via rs*_pending. If it occurs anyway, A writes immediately, the queued entry writes later, and nothing is squashed.
- Reset asserted mid-operation discards all queued entries; no write for them ever occurs.

Test Plan:
- Reset then idle -> b_ready=1, w_enable=0, fifo_count=0, stall_a=0; with a_valid=1, a_addr=5, a_data=0x11 -> same cycle w_enable=1, w_addr=5, w_data=0x11.
- B accepts x7=0xAB at cycle N with A idle -> fifo_count=1 at N+1, rs1_pending=1 for rs1_addr=7 at N+1, write of x7=0xAB in cycle N+1, pending=0 and count=0 at N+2.
- A valid every cycle with DEPTH=2: B enqueues x3 then x4 -> b_ready=0 after the 2nd accept; stall_a=1 after 4 losing cycles; A drops -> x3 then x4 written in order; stall_a=0 the cycle after the x3 write.
- Full FIFO, head draining while b_valid=1 -> b_ready=0 that cycle, no accept, fifo_count goes 2 -> 1; accept happens the next cycle.
- B with b_addr=0 -> handshake completes, fifo_count unchanged, no write; a_addr=0 with a queued x9 -> x9 written that cycle.
- rstd pulsed low mid-cycle with 2 entries queued -> fifo_count=0 and pending=0 immediately, w_enable=0 while low, no queued write after release.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter. The pipeline writeback (A) always wins the
// port. The long-latency unit (B) queues into a small FIFO that drains whenever
// A leaves the port idle. The block also drives pending flags for the hazard
// unit and a registered stall request when the FIFO has been starved.
module reg_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rstd,
    input  logic                       a_valid,
    input  logic [4:0]                 a_addr,
    input  logic [31:0]                a_data,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [4:0]                 b_addr,
    input  logic [31:0]                b_data,
    output logic                       w_enable,
    output logic [4:0]                 w_addr,
    output logic [31:0]                w_data,
    input  logic [4:0]                 rs1_addr,
    input  logic [4:0]                 rs2_addr,
    output logic                       rs1_pending,
    output logic                       rs2_pending,
    output logic                       stall_a,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int          CW = $clog2(DEPTH + 1);
    localparam int          PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  SL = 4'(STARVE_LIMIT);

    logic [4:0]        mem_addr_q [DEPTH];
    logic [31:0]       mem_data_q [DEPTH];
    logic [DEPTH-1:0]  occ_q, occ_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [3:0]        starve_q, starve_d;
    logic              stall_q, stall_d;

    logic full, empty, a_win, enq, deq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign b_ready    = !full;
    assign a_win      = rstd && a_valid && (a_addr != 5'd0);
    // x0 results complete the handshake but never occupy an entry
    assign enq        = b_valid && b_ready && (b_addr != 5'd0);
    assign deq        = rstd && !a_win && !empty;
    assign fifo_count = count_q;
    assign stall_a    = stall_q;

    // Fixed-priority write port: A first, then the FIFO head, else idle zeros
    always_comb begin
        w_enable = 1'b0;
        w_addr   = 5'd0;
        w_data   = 32'd0;
        if (a_win) begin
            w_enable = 1'b1;
            w_addr   = a_addr;
            w_data   = a_data;
        end else if (deq) begin
            w_enable = 1'b1;
            w_addr   = mem_addr_q[head_q];
            w_data   = mem_data_q[head_q];
        end
    end

    // Pointer, occupancy and count next-state; enqueue and dequeue are independent
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        count_d = count_q + CW'(enq) - CW'(deq);
        if (deq) begin
            occ_d[head_q] = 1'b0;
            head_d        = ptr_inc(head_q);
        end
        if (enq) begin
            occ_d[tail_q] = 1'b1;
            tail_d        = ptr_inc(tail_q);
        end
    end

    // Starve counter: counts cycles A holds the port over a waiting head
    always_comb begin
        starve_d = starve_q;
        if (empty || deq)
            starve_d = 4'd0;
        else if (a_win && starve_q != SL)
            starve_d = starve_q + 4'd1;
        stall_d = (starve_d == SL);
    end

    // Pending flags look only at stored entries
    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ_q[i] && mem_addr_q[i] == rs1_addr) rs1_pending = 1'b1;
            if (occ_q[i] && mem_addr_q[i] == rs2_addr) rs2_pending = 1'b1;
        end
        if (rs1_addr == 5'd0) rs1_pending = 1'b0;
        if (rs2_addr == 5'd0) rs2_pending = 1'b0;
    end

    // Control state; reset discards every queued entry
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            head_q   <= '0;
            tail_q   <= '0;
            occ_q    <= '0;
            count_q  <= '0;
            starve_q <= 4'd0;
            stall_q  <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            occ_q    <= occ_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    // Entry payload storage; validity lives in occ_q so no reset is needed here
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_addr_q[tail_q] <= b_addr;
            mem_data_q[tail_q] <= b_data;
        end
    end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: a queue-based reference model checked every cycle,
// plus directed vectors with hand-computed values.
module tb_reg_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int LIM   = 4;

    logic        clk = 1'b0;
    logic        rstd = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_addr = 5'd0, b_addr = 5'd0, rs1_addr = 5'd0, rs2_addr = 5'd0;
    logic [31:0] a_data = 32'd0, b_data = 32'd0;
    logic        b_ready, w_enable, rs1_pending, rs2_pending, stall_a;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [1:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    reg_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rstd(rstd),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .stall_a(stall_a), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: a plain queue of (addr,data) plus a starve count
    typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t mq[$];
    int   mst   = 0;
    bit   mstall = 1'b0;

    always @(negedge clk) begin
        if (!rstd) begin
            chk("m_rst_wen", w_enable, 0);
            chk("m_rst_cnt", fifo_count, 0);
            chk("m_rst_rdy", b_ready, 1);
            chk("m_rst_stall", stall_a, 0);
            chk("m_rst_pend", {rs1_pending, rs2_pending}, 0);
            mq.delete();
            mst    = 0;
            mstall = 1'b0;
        end else begin
            bit    awin, pop, p1, p2;
            ent_t  hd;
            int    sz;
            sz   = mq.size();
            awin = a_valid && a_addr != 0;
            pop  = !awin && sz > 0;
            p1 = 0; p2 = 0;
            foreach (mq[i]) begin
                if (rs1_addr != 0 && mq[i].a == rs1_addr) p1 = 1;
                if (rs2_addr != 0 && mq[i].a == rs2_addr) p2 = 1;
            end
            hd = (sz > 0) ? mq[0] : '0;
            chk("m_wen", w_enable, awin || pop);
            chk("m_waddr", w_addr, awin ? a_addr : (pop ? hd.a : 5'd0));
            chk("m_wdata", w_data, awin ? a_data : (pop ? hd.d : 32'd0));
            chk("m_rdy", b_ready, sz < DEPTH);
            chk("m_cnt", fifo_count, sz);
            chk("m_p1", rs1_pending, p1);
            chk("m_p2", rs2_pending, p2);
            chk("m_stall", stall_a, mstall);
            // advance the model to the state after the coming posedge
            if (pop) void'(mq.pop_front());
            if (b_valid && sz < DEPTH && b_addr != 0) mq.push_back({b_addr, b_data});
            if (sz == 0 || pop) mst = 0;
            else if (mst < LIM) mst++;
            mstall = (mst == LIM);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask
    task automatic settle();
        #2;
    endtask
    task automatic setA(input logic v, input logic [4:0] ad, input logic [31:0] d);
        a_valid = v; a_addr = ad; a_data = d;
    endtask
    task automatic setB(input logic v, input logic [4:0] ad, input logic [31:0] d);
        b_valid = v; b_addr = ad; b_data = d;
    endtask

    initial begin
        // reset, then idle
        step(); step();
        rstd = 1'b1;
        settle();
        chk("rst_ready", b_ready, 1);
        chk("rst_wen", w_enable, 0);
        chk("rst_cnt", fifo_count, 0);
        chk("rst_stall", stall_a, 0);
        setA(1, 5, 32'h11);
        settle();
        chk("a_pass", {w_enable, w_addr, w_data}, {1'b1, 5'd5, 32'h11});
        step();

        // single B entry x7
        setA(0, 0, 0);
        setB(1, 7, 32'hAB);
        rs1_addr = 7;
        settle();
        chk("b_no_bypass", w_enable, 0);
        chk("b_p_before", rs1_pending, 0);
        step();
        setB(0, 0, 0);
        settle();
        chk("b_cnt1", fifo_count, 1);
        chk("b_pend1", rs1_pending, 1);
        chk("b_write", {w_enable, w_addr, w_data}, {1'b1, 5'd7, 32'hAB});
        step();
        settle();
        chk("b_cnt0", fifo_count, 0);
        chk("b_pend0", rs1_pending, 0);
        rs1_addr = 0;

        // starvation: A busy, x3 then x4 queued
        setA(1, 1, 32'h100);
        setB(1, 3, 32'h33);
        step();
        setA(1, 1, 32'h101);
        setB(1, 4, 32'h44);
        step();
        setB(0, 0, 0);
        settle();
        chk("s_full_rdy", b_ready, 0);
        chk("s_cnt2", fifo_count, 2);
        step(); step();
        settle();
        chk("s_stall_c4", stall_a, 0);
        step();
        settle();
        chk("s_stall_c5", stall_a, 1);
        chk("s_a_wins", w_addr, 1);
        step();
        setA(0, 0, 0);
        settle();
        chk("s_stall_sat", stall_a, 1);
        chk("s_x3", {w_enable, w_addr, w_data}, {1'b1, 5'd3, 32'h33});
        step();
        settle();
        chk("s_stall_clr", stall_a, 0);
        chk("s_x4", {w_addr, w_data}, {5'd4, 32'h44});
        step();
        settle();
        chk("s_empty", {w_enable, fifo_count}, 3'b000);

        // full FIFO draining with b_valid held
        setA(1, 1, 32'h200);
        setB(1, 10, 32'hA);
        step();
        setB(1, 11, 32'hB);
        step();
        setA(0, 0, 0);
        setB(1, 12, 32'hC);
        settle();
        chk("f_rdy0", b_ready, 0);
        chk("f_x10", w_addr, 10);
        step();
        settle();
        chk("f_cnt1", fifo_count, 1);
        chk("f_rdy1", b_ready, 1);
        chk("f_x11", w_addr, 11);
        step();
        setB(0, 0, 0);
        settle();
        chk("f_cnt_hold", fifo_count, 1);
        chk("f_x12", {w_addr, w_data}, {5'd12, 32'hC});
        step();

        // x0 B entry is swallowed; a_addr=0 lets the head through
        setB(1, 0, 32'h55);
        settle();
        chk("z_rdy", b_ready, 1);
        step();
        setB(0, 0, 0);
        settle();
        chk("z_cnt", fifo_count, 0);
        chk("z_nowrite", w_enable, 0);
        setB(1, 9, 32'h99);
        step();
        setB(0, 0, 0);
        setA(1, 0, 32'h77);
        settle();
        chk("z_x9", {w_enable, w_addr, w_data}, {1'b1, 5'd9, 32'h99});
        step();
        setA(0, 0, 0);

        // mid-operation reset discards queued entries
        setA(1, 1, 32'h300);
        rs1_addr = 20; rs2_addr = 21;
        setB(1, 20, 32'h20);
        step();
        setB(1, 21, 32'h21);
        step();
        setB(0, 0, 0);
        settle();
        chk("r_pend", {rs1_pending, rs2_pending}, 2'b11);
        rstd = 1'b0;
        #1;
        chk("r_cnt", fifo_count, 0);
        chk("r_pend0", {rs1_pending, rs2_pending}, 2'b00);
        chk("r_wen", w_enable, 0);
        step();
        rstd = 1'b1;
        setA(0, 0, 0);
        settle();
        chk("r_after", {w_enable, fifo_count}, 3'b000);
        step();
        settle();
        chk("r_after2", w_enable, 0);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
